alu_sequencer: RTL and testbench

Instruction fetch/decode/issue stage directly upstream of the register-file ALU. Fetches 16-bit instruction words over a shared von Neumann memory bus, decodes them into the ALU control bundle (operand/result indices, one-hot `operation` with bit 6 as the write strobe, `params`, `readBus`/`din`), and performs loads, stores, immediates and conditional branches on the ALU `status` flags. Issues one instruction at a time; the state machine below defines all sequencing.

---
 rtl/seq_pkg.sv | 70 +++++++
 rtl/seq_decode.sv | 33 +++
 rtl/alu_sequencer.sv | 146 ++++++++++++++
 tb/tb_alu_sequencer.sv | 235 +++++++++++++++++++++++
 4 files changed

// File: rtl/seq_pkg.sv
// Shared opcodes, state/class encodings, ALU operation constants and decode bundle
// for the ALU instruction sequencer.
package seq_pkg;

  localparam int unsigned XLEN   = 16;
  localparam int unsigned OPW    = 7;
  localparam int unsigned PARW   = 4;
  localparam int unsigned IDXW   = 3;
  localparam int unsigned STATW  = 6;

  localparam logic [3:0] OP_NOP  = 4'h0;
  localparam logic [3:0] OP_ADD  = 4'h1;
  localparam logic [3:0] OP_MUL  = 4'h2;
  localparam logic [3:0] OP_LOG  = 4'h3;
  localparam logic [3:0] OP_SHL  = 4'h4;
  localparam logic [3:0] OP_SHR  = 4'h5;
  localparam logic [3:0] OP_CMP  = 4'h6;
  localparam logic [3:0] OP_LDI  = 4'h7;
  localparam logic [3:0] OP_LD   = 4'h8;
  localparam logic [3:0] OP_ST   = 4'h9;
  localparam logic [3:0] OP_ADDI = 4'hA;
  localparam logic [3:0] OP_BR   = 4'hC;
  localparam logic [3:0] OP_HALT = 4'hF;

  localparam logic [OPW-1:0] ALU_LOAD = 7'h40;
  localparam logic [OPW-1:0] ALU_ADD  = 7'h41;
  localparam logic [OPW-1:0] ALU_MUL  = 7'h42;
  localparam logic [OPW-1:0] ALU_LOG  = 7'h44;
  localparam logic [OPW-1:0] ALU_SHL  = 7'h48;
  localparam logic [OPW-1:0] ALU_SHR  = 7'h50;
  localparam logic [OPW-1:0] ALU_CMP  = 7'h60;

  localparam logic [2:0] CC_Z      = 3'd0;
  localparam logic [2:0] CC_C      = 3'd1;
  localparam logic [2:0] CC_N      = 3'd2;
  localparam logic [2:0] CC_EQ     = 3'd3;
  localparam logic [2:0] CC_GT     = 3'd4;
  localparam logic [2:0] CC_LT     = 3'd5;
  localparam logic [2:0] CC_ALWAYS = 3'd6;
  localparam logic [2:0] CC_NEVER  = 3'd7;

  typedef enum logic [2:0] {
    S_FETCH, S_DECODE, S_IMM, S_MEM_RD, S_EXEC, S_WB, S_MEM_WR, S_HALT
  } state_t;

  typedef enum logic [2:0] {
    CL_NOP, CL_REG, CL_LDI, CL_LD, CL_ST, CL_ADDI, CL_BR, CL_HALT
  } iclass_t;

  typedef struct packed {
    iclass_t             cls;
    logic [OPW-1:0]      operation;
    logic [PARW-1:0]     params;
    logic                two_word;
    logic                illegal;
  } dec_t;

  // Branch condition: status bit select, always/never, optional inversion.
  function automatic logic br_taken(input logic [2:0] cond, input logic inv,
                                    input logic [STATW-1:0] status);
    logic c;
    case (cond)
      CC_ALWAYS: c = 1'b1;
      CC_NEVER:  c = 1'b0;
      default:   c = status[cond];
    endcase
    return c ^ inv;
  endfunction

endpackage

// File: rtl/seq_decode.sv
// Combinational instruction decode: IR -> class, ALU operation, params, word count, illegal.
module seq_decode
  import seq_pkg::*;
(
  input  logic [XLEN-1:0] ir,
  output dec_t            dec
);

  always_comb begin
    dec.cls       = CL_NOP;
    dec.operation = '0;
    dec.params    = {1'b0, ir[2:0]};
    dec.two_word  = 1'b0;
    dec.illegal   = 1'b0;
    case (ir[15:12])
      OP_NOP:  dec.cls = CL_NOP;
      OP_ADD:  begin dec.cls = CL_REG; dec.operation = ALU_ADD; end
      OP_MUL:  begin dec.cls = CL_REG; dec.operation = ALU_MUL; end
      OP_LOG:  begin dec.cls = CL_REG; dec.operation = ALU_LOG; end
      OP_SHL:  begin dec.cls = CL_REG; dec.operation = ALU_SHL; dec.params = ir[3:0]; end
      OP_SHR:  begin dec.cls = CL_REG; dec.operation = ALU_SHR; dec.params = ir[3:0]; end
      OP_CMP:  begin dec.cls = CL_REG; dec.operation = ALU_CMP; end
      OP_LDI:  begin dec.cls = CL_LDI; dec.operation = ALU_LOAD; dec.two_word = 1'b1; end
      OP_LD:   begin dec.cls = CL_LD;  dec.operation = ALU_LOAD; end
      OP_ST:   begin dec.cls = CL_ST;  dec.two_word = 1'b1; end
      OP_ADDI: begin dec.cls = CL_ADDI; dec.operation = ALU_ADD; dec.two_word = 1'b1; end
      OP_BR:   begin dec.cls = CL_BR;  dec.two_word = 1'b1; end
      OP_HALT: dec.cls = CL_HALT;
      default: dec.illegal = 1'b1;
    endcase
  end

endmodule

// File: rtl/alu_sequencer.sv
// Fetch/decode/issue sequencer driving the register-file ALU over a shared memory bus.
module alu_sequencer
  import seq_pkg::*;
#(
  parameter logic [15:0] RESET_VECTOR = 16'h0000
) (
  input  logic              CLK,
  input  logic              RST_N,
  output logic              memReq,
  output logic              memWe,
  output logic [XLEN-1:0]   memAddr,
  output logic [XLEN-1:0]   memWdata,
  input  logic [XLEN-1:0]   memRdata,
  input  logic              memAck,
  output logic [IDXW-1:0]   aluOperandIndex1,
  output logic [IDXW-1:0]   aluOperandIndex2,
  output logic [IDXW-1:0]   aluResultsIndex,
  output logic [OPW-1:0]    aluOperation,
  output logic [PARW-1:0]   aluParams,
  output logic              aluReadBus,
  output logic [XLEN-1:0]   aluDin,
  input  logic [XLEN-1:0]   aluDout,
  input  logic [STATW-1:0]  aluStatus,
  output logic [XLEN-1:0]   pc,
  output logic              halted,
  output logic              illegal
);

  state_t          state_q, state_d;
  logic [XLEN-1:0] pc_q, ir_q, imm_q, data_q;
  logic            req_c;
  logic            xfer;
  dec_t            dec;

  seq_decode u_decode (
    .ir  (ir_q),
    .dec (dec)
  );

  assign xfer = memReq && memAck;

  // State register
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) state_q <= S_FETCH;
    else        state_q <= state_d;
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_FETCH:  if (xfer) state_d = S_DECODE;
      S_DECODE: begin
        if (dec.two_word)            state_d = S_IMM;
        else if (dec.cls == CL_LD)   state_d = S_MEM_RD;
        else if (dec.cls == CL_HALT) state_d = S_HALT;
        else if (dec.cls == CL_NOP)  state_d = S_FETCH;
        else                         state_d = S_EXEC;
      end
      S_IMM: begin
        if (xfer) begin
          if (dec.cls == CL_BR)      state_d = S_FETCH;
          else if (dec.cls == CL_ST) state_d = S_MEM_WR;
          else                       state_d = S_EXEC;
        end
      end
      S_MEM_RD: if (xfer) state_d = S_WB;
      S_EXEC:   state_d = S_FETCH;
      S_WB:     state_d = S_FETCH;
      S_MEM_WR: if (xfer) state_d = S_FETCH;
      S_HALT:   state_d = S_HALT;
      default:  state_d = S_FETCH;
    endcase
  end

  // Instruction, immediate, load-data and PC registers
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      pc_q   <= RESET_VECTOR;
      ir_q   <= '0;
      imm_q  <= '0;
      data_q <= '0;
    end else if (xfer) begin
      case (state_q)
        S_FETCH: begin
          ir_q <= memRdata;
          pc_q <= pc_q + XLEN'(1);
        end
        S_IMM: begin
          imm_q <= memRdata;
          if (dec.cls == CL_BR && br_taken(ir_q[2:0], ir_q[3], aluStatus))
            pc_q <= memRdata;
          else
            pc_q <= pc_q + XLEN'(1);
        end
        S_MEM_RD: data_q <= memRdata;
        default: ;
      endcase
    end
  end

  // Output logic; the bus request is masked while reset is held so it drops immediately.
  always_comb begin
    req_c        = 1'b0;
    memWe        = 1'b0;
    memAddr      = pc_q;
    memWdata     = '0;
    aluOperation = '0;
    aluReadBus   = 1'b0;
    aluDin       = '0;
    case (state_q)
      S_FETCH, S_IMM: req_c = 1'b1;
      S_MEM_RD: begin
        req_c   = 1'b1;
        memAddr = aluDout;
      end
      S_MEM_WR: begin
        req_c    = 1'b1;
        memWe    = 1'b1;
        memAddr  = imm_q;
        memWdata = aluDout;
      end
      S_EXEC: begin
        aluOperation = dec.operation;
        aluReadBus   = (dec.cls == CL_LDI) || (dec.cls == CL_ADDI);
        aluDin       = imm_q;
      end
      S_WB: begin
        aluOperation = dec.operation;
        aluReadBus   = 1'b1;
        aluDin       = data_q;
      end
      default: ;
    endcase
  end

  assign memReq           = req_c && RST_N;
  assign aluResultsIndex  = ir_q[11:9];
  assign aluOperandIndex1 = ir_q[8:6];
  assign aluOperandIndex2 = ir_q[5:3];
  assign aluParams        = dec.params;
  assign pc               = pc_q;
  assign halted           = (state_q == S_HALT);
  assign illegal          = (state_q == S_DECODE) && dec.illegal;

endmodule

// File: tb/tb_alu_sequencer.sv
// Directed self-checking bench for alu_sequencer with a small word memory model.
module tb_alu_sequencer;

  logic        CLK = 1'b0;
  logic        RST_N = 1'b0;
  logic        memReq, memWe, memAck;
  logic [15:0] memAddr, memWdata, memRdata;
  logic [2:0]  idx1, idx2, ridx;
  logic [6:0]  aluOperation;
  logic [3:0]  aluParams;
  logic        aluReadBus;
  logic [15:0] aluDin;
  logic [15:0] aluDout = 16'h0;
  logic [5:0]  aluStatus = 6'h0;
  logic [15:0] pc;
  logic        halted, illegal;

  logic [15:0] mem [0:255];
  int          wr_delay = 0;
  int          wait_cnt;
  logic [15:0] wr_addr, wr_data;
  int          checks = 0;
  int          errors = 0;

  always #5 CLK = ~CLK;

  alu_sequencer #(.RESET_VECTOR(16'h0000)) dut (
    .CLK(CLK), .RST_N(RST_N),
    .memReq(memReq), .memWe(memWe), .memAddr(memAddr), .memWdata(memWdata),
    .memRdata(memRdata), .memAck(memAck),
    .aluOperandIndex1(idx1), .aluOperandIndex2(idx2), .aluResultsIndex(ridx),
    .aluOperation(aluOperation), .aluParams(aluParams), .aluReadBus(aluReadBus),
    .aluDin(aluDin), .aluDout(aluDout), .aluStatus(aluStatus),
    .pc(pc), .halted(halted), .illegal(illegal)
  );

  assign memRdata = mem[memAddr[7:0]];
  assign memAck   = memReq && (!memWe || wait_cnt >= wr_delay);

  always @(posedge CLK or negedge RST_N) begin
    if (!RST_N)                 wait_cnt <= 0;
    else if (memReq && !memAck) wait_cnt <= wait_cnt + 1;
    else                        wait_cnt <= 0;
  end

  always @(posedge CLK) begin
    if (memReq && memAck && memWe) begin
      wr_addr <= memAddr;
      wr_data <= memWdata;
    end
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s observed %h expected %h", tag, got, exp);
    end
  endtask

  task automatic clear_mem();
    for (int i = 0; i < 256; i++) mem[i] = 16'h0000;
  endtask

  task automatic nxt();
    @(negedge CLK); #1;
  endtask

  task automatic hold_reset();
    RST_N = 1'b0;
    @(negedge CLK); @(negedge CLK);
  endtask

  task automatic release_reset();
    RST_N = 1'b1; #1;
  endtask

  initial begin
    // Reset state and ADD r2=r0+r1
    clear_mem();
    mem[0] = 16'h1408;
    hold_reset();
    chk("rst_memReq", 32'(memReq), 32'd0);
    chk("rst_pc", 32'(pc), 32'h0);
    chk("rst_op", 32'(aluOperation), 32'h0);
    chk("rst_halted", 32'(halted), 32'd0);
    chk("rst_illegal", 32'(illegal), 32'd0);
    chk("rst_rbus", 32'(aluReadBus), 32'd0);
    release_reset();
    chk("add_fetch_req", 32'(memReq), 32'd1);
    chk("add_fetch_addr", 32'(memAddr), 32'h0);
    chk("add_fetch_we", 32'(memWe), 32'd0);
    nxt();
    chk("add_dec_op", 32'(aluOperation), 32'h0);
    chk("add_dec_req", 32'(memReq), 32'd0);
    nxt();
    chk("add_exec_op", 32'(aluOperation), 32'h41);
    chk("add_idx1", 32'(idx1), 32'd0);
    chk("add_idx2", 32'(idx2), 32'd1);
    chk("add_ridx", 32'(ridx), 32'd2);
    chk("add_pc", 32'(pc), 32'h1);
    chk("add_rbus", 32'(aluReadBus), 32'd0);
    nxt();
    chk("add_after_op", 32'(aluOperation), 32'h0);
    chk("add_next_addr", 32'(memAddr), 32'h1);

    // LDI r0,0x1234
    clear_mem();
    mem[0] = 16'h7000; mem[1] = 16'h1234;
    hold_reset(); release_reset();
    nxt();
    nxt();
    chk("ldi_imm_req", 32'(memReq), 32'd1);
    chk("ldi_imm_addr", 32'(memAddr), 32'h1);
    chk("ldi_imm_op", 32'(aluOperation), 32'h0);
    nxt();
    chk("ldi_op", 32'(aluOperation), 32'h40);
    chk("ldi_rbus", 32'(aluReadBus), 32'd1);
    chk("ldi_din", 32'(aluDin), 32'h1234);
    chk("ldi_ridx", 32'(ridx), 32'd0);
    chk("ldi_pc", 32'(pc), 32'h2);
    nxt();
    chk("ldi_after_rbus", 32'(aluReadBus), 32'd0);
    chk("ldi_next_addr", 32'(memAddr), 32'h2);

    // LD r0,[r2] with aluDout as address
    clear_mem();
    mem[0] = 16'h8080; mem[16'h50] = 16'h5A5A;
    aluDout = 16'h0050;
    hold_reset(); release_reset();
    nxt();
    nxt();
    chk("ld_rd_addr", 32'(memAddr), 32'h50);
    chk("ld_rd_we", 32'(memWe), 32'd0);
    nxt();
    chk("ld_wb_op", 32'(aluOperation), 32'h40);
    chk("ld_wb_rbus", 32'(aluReadBus), 32'd1);
    chk("ld_wb_din", 32'(aluDin), 32'h5A5A);
    nxt();
    chk("ld_next_addr", 32'(memAddr), 32'h1);

    // SHL r1: params come from instr[3:0]
    clear_mem();
    mem[0] = 16'h420B;
    hold_reset(); release_reset();
    nxt(); nxt();
    chk("shl_op", 32'(aluOperation), 32'h48);
    chk("shl_params", 32'(aluParams), 32'hB);
    chk("shl_ridx", 32'(ridx), 32'd1);

    // BR EQ taken / not taken, inverted, never
    clear_mem();
    mem[0] = 16'hC003; mem[1] = 16'h0040;
    aluStatus = 6'b001000;
    hold_reset(); release_reset();
    nxt(); nxt();
    chk("br_imm_op6", 32'(aluOperation[6]), 32'd0);
    nxt();
    chk("br_taken_addr", 32'(memAddr), 32'h40);
    chk("br_taken_req", 32'(memReq), 32'd1);
    aluStatus = 6'b000000;
    hold_reset(); release_reset();
    nxt(); nxt(); nxt();
    chk("br_not_taken_addr", 32'(memAddr), 32'h2);
    mem[0] = 16'hC00B;
    hold_reset(); release_reset();
    nxt(); nxt(); nxt();
    chk("br_inv_taken_addr", 32'(memAddr), 32'h40);
    mem[0] = 16'hC007;
    aluStatus = 6'b111111;
    hold_reset(); release_reset();
    nxt(); nxt(); nxt();
    chk("br_never_addr", 32'(memAddr), 32'h2);
    aluStatus = 6'b000000;

    // ST [0x0100],r2 with 3 wait cycles on the write
    clear_mem();
    mem[0] = 16'h9080; mem[1] = 16'h0100;
    aluDout = 16'hBEEF;
    wr_delay = 3;
    hold_reset(); release_reset();
    nxt(); nxt();
    for (int i = 0; i < 4; i++) begin
      nxt();
      chk("st_we", 32'(memWe), 32'd1);
      chk("st_req", 32'(memReq), 32'd1);
      chk("st_addr", 32'(memAddr), 32'h0100);
      chk("st_wdata", 32'(memWdata), 32'hBEEF);
    end
    nxt();
    chk("st_done_we", 32'(memWe), 32'd0);
    chk("st_next_addr", 32'(memAddr), 32'h2);
    chk("st_wr_addr", 32'(wr_addr), 32'h0100);
    chk("st_wr_data", 32'(wr_data), 32'hBEEF);

    // Reset during MEM_WR abandons the transfer
    hold_reset(); release_reset();
    nxt(); nxt(); nxt();
    chk("rstwr_pre_we", 32'(memWe), 32'd1);
    RST_N = 1'b0; #1;
    chk("rstwr_req_drop", 32'(memReq), 32'd0);
    @(negedge CLK);
    release_reset();
    chk("rstwr_fetch_addr", 32'(memAddr), 32'h0);
    chk("rstwr_fetch_we", 32'(memWe), 32'd0);
    chk("rstwr_pc", 32'(pc), 32'h0);
    wr_delay = 0;

    // Illegal opcode then HALT
    clear_mem();
    mem[0] = 16'hD000; mem[1] = 16'hF000;
    hold_reset(); release_reset();
    chk("ill_fetch", 32'(illegal), 32'd0);
    nxt();
    chk("ill_pulse", 32'(illegal), 32'd1);
    chk("ill_op", 32'(aluOperation), 32'h0);
    nxt();
    chk("ill_clear", 32'(illegal), 32'd0);
    chk("ill_next_addr", 32'(memAddr), 32'h1);
    chk("ill_next_req", 32'(memReq), 32'd1);
    nxt();
    chk("halt_dec_halted", 32'(halted), 32'd0);
    nxt();
    for (int i = 0; i < 8; i++) begin
      chk("halt_halted", 32'(halted), 32'd1);
      chk("halt_req", 32'(memReq), 32'd0);
      nxt();
    end
    chk("halt_pc", 32'(pc), 32'h2);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
